sound_wave_ram: RTL and testbench

SOUND_WAVE_RAM -- requirements
Module: sound_wave_ram

---
 rtl/sound_wave_ram.sv | 110 +++++++++++
 tb/tb_sound_wave_ram.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sound_wave_ram.sv
// sound_wave_ram: 16-byte channel-3 wave RAM with a CPU port at 0xFF30-0xFF3F
// and a two-stage playback pipeline (position update, then nibble fetch).
// Optional build macro WAVE_RAM_LOCK_EN: while iPlay is high, CPU accesses in
// range are redirected to the byte currently being played (DMG access quirk).
module sound_wave_ram (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iAddr,
    input  logic [7:0]  iData,
    input  logic        iWe,
    input  logic        iRe,
    output logic [7:0]  oData,
    output logic        oDataValid,
    input  logic        iPlay,
    input  logic        iTrigger,
    input  logic        iStepReq,
    output logic [3:0]  oSample,
    output logic        oSampleValid,
    output logic [4:0]  oPosition
);

    localparam int unsigned ByteCount = 16;
    localparam int unsigned IdxW      = 4;
    localparam int unsigned ByteW     = 8;

    // Power-on triangle wave, byte 0 in the most significant position
    localparam logic [ByteCount*ByteW-1:0] Triangle =
        128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic [ByteW-1:0] ram [ByteCount];
    logic             inRange;
    logic [IdxW-1:0]  cpuIdx;
    logic             fetchPending;
    logic [ByteW-1:0] fetchByte;
    logic [3:0]       fetchNibble;

    // Address decode for the 0xFF30-0xFF3F window
    always_comb begin
        inRange = (iAddr[15:4] == 12'hFF3);
    end

    // CPU byte select; the lock build follows the playback pointer while playing
    always_comb begin
`ifdef WAVE_RAM_LOCK_EN
        cpuIdx = iPlay ? oPosition[4:1] : iAddr[3:0];
`else
        cpuIdx = iAddr[3:0];
`endif
    end

    // Nibble at the current pointer; even positions use the high nibble
    always_comb begin
        fetchByte   = ram[oPosition[4:1]];
        fetchNibble = oPosition[0] ? fetchByte[3:0] : fetchByte[7:4];
    end

    // Wave storage: reset loads the triangle, CPU writes otherwise
    always_ff @(posedge iClock) begin
        if (iReset) begin
            for (int k = 0; k < ByteCount; k++) begin
                ram[k] <= Triangle[ByteW*(ByteCount-1-k) +: ByteW];
            end
        end else if (iWe && inRange) begin
            ram[cpuIdx] <= iData;
        end
    end

    // CPU read port: returns the pre-write byte, data held between reads
    always_ff @(posedge iClock) begin
        if (iReset) begin
            oData      <= 8'h00;
            oDataValid <= 1'b0;
        end else if (iRe && inRange) begin
            oData      <= ram[cpuIdx];
            oDataValid <= 1'b1;
        end else begin
            oDataValid <= 1'b0;
        end
    end

    // Pipeline stage 1: playback pointer; trigger beats step
    always_ff @(posedge iClock) begin
        if (iReset) begin
            oPosition    <= 5'd0;
            fetchPending <= 1'b0;
        end else if (iTrigger) begin
            oPosition    <= 5'd0;
            fetchPending <= 1'b1;
        end else if (iStepReq && iPlay) begin
            oPosition    <= oPosition + 5'd1;
            fetchPending <= 1'b1;
        end else begin
            fetchPending <= 1'b0;
        end
    end

    // Pipeline stage 2: fetch the sample at the new pointer (read-before-write)
    always_ff @(posedge iClock) begin
        if (iReset) begin
            oSample      <= 4'h0;
            oSampleValid <= 1'b0;
        end else if (fetchPending) begin
            oSample      <= fetchNibble;
            oSampleValid <= 1'b1;
        end else begin
            oSampleValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sound_wave_ram.sv
// tb_sound_wave_ram: table-driven vectors, hand-written corner sequences and a
// randomized run compared against a behavioural model of the wave RAM.
module tb_sound_wave_ram;

    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic [15:0] iAddr = 16'h0000;
    logic [7:0]  iData = 8'h00;
    logic        iWe = 1'b0;
    logic        iRe = 1'b0;
    logic [7:0]  oData;
    logic        oDataValid;
    logic        iPlay = 1'b0;
    logic        iTrigger = 1'b0;
    logic        iStepReq = 1'b0;
    logic [3:0]  oSample;
    logic        oSampleValid;
    logic [4:0]  oPosition;

    int testsRun = 0;
    int testsFailed = 0;

    sound_wave_ram dut (
        .iClock(iClock), .iReset(iReset), .iAddr(iAddr), .iData(iData),
        .iWe(iWe), .iRe(iRe), .oData(oData), .oDataValid(oDataValid),
        .iPlay(iPlay), .iTrigger(iTrigger), .iStepReq(iStepReq),
        .oSample(oSample), .oSampleValid(oSampleValid), .oPosition(oPosition)
    );

    always #5 iClock = ~iClock;

    // Behavioural model state
    logic [7:0] mRam [16];
    int         mPos;
    bit         mFetchDue;
    int         mSample, mSv, mData, mDv;

    function automatic logic [7:0] triangleByte(input int k);
        int hi, lo;
        if (k < 8) begin hi = 2*k; lo = 2*k + 1; end
        else begin hi = 31 - 2*k; lo = 30 - 2*k; end
        return 8'((hi << 4) | lo);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, sample outputs after the edge
    task automatic cycle(input bit rst, input logic [15:0] addr, input logic [7:0] data,
                         input bit we, input bit re, input bit play,
                         input bit trig, input bit step);
        bit         inr;
        int         idx;
        logic [7:0] oldByte, playByte;
        iReset = rst; iAddr = addr; iData = data; iWe = we; iRe = re;
        iPlay = play; iTrigger = trig; iStepReq = step;
        if (rst) begin
            for (int k = 0; k < 16; k++) mRam[k] = triangleByte(k);
            mPos = 0; mFetchDue = 0; mSample = 0; mSv = 0; mData = 0; mDv = 0;
        end else begin
            inr = (addr >= 16'hFF30) && (addr <= 16'hFF3F);
            idx = int'(addr) - 'hFF30;
`ifdef WAVE_RAM_LOCK_EN
            if (play) idx = mPos / 2;
`endif
            if (inr) oldByte = mRam[idx];
            else oldByte = 8'h00;
            if (mFetchDue) begin
                playByte = mRam[mPos / 2];
                mSample = (mPos % 2 == 1) ? int'(playByte[3:0]) : int'(playByte[7:4]);
                mSv = 1;
            end else mSv = 0;
            if (re && inr) begin mData = int'(oldByte); mDv = 1; end
            else mDv = 0;
            if (we && inr) mRam[idx] = data;
            if (trig) begin mPos = 0; mFetchDue = 1; end
            else if (step && play) begin mPos = (mPos + 1) % 32; mFetchDue = 1; end
            else mFetchDue = 0;
        end
        @(posedge iClock);
        #1;
    endtask

    task automatic idle(input bit play);
        cycle(0, 16'h0000, 8'h00, 0, 0, play, 0, 0);
    endtask

    typedef struct {
        bit rst; logic [15:0] addr; logic [7:0] data;
        bit we; bit re; bit play; bit trig; bit step;
        int ePos; int eSample; int eSv; int eDv; int eData;
    } vec_t;

    vec_t vecs [15];

    initial begin : main
        int svCount;
        int expB3, expB15;

        // rst addr data we re play trig step | pos sample sv dv data
        vecs[0]  = '{1, 16'h0000, 8'h00, 0, 0, 0, 0, 0,  0, 'h0, 0, 0, 'h00};
        vecs[1]  = '{0, 16'hFF37, 8'h00, 0, 1, 0, 0, 0,  0, 'h0, 0, 1, 'hEF};
        vecs[2]  = '{0, 16'h0000, 8'h00, 0, 0, 0, 0, 0,  0, 'h0, 0, 0, 'hEF};
        vecs[3]  = '{0, 16'hFF30, 8'hA5, 1, 0, 0, 0, 0,  0, 'h0, 0, 0, 'hEF};
        vecs[4]  = '{0, 16'h0000, 8'h00, 0, 0, 0, 1, 0,  0, 'h0, 0, 0, 'hEF};
        vecs[5]  = '{0, 16'h0000, 8'h00, 0, 0, 1, 0, 0,  0, 'hA, 1, 0, 'hEF};
        vecs[6]  = '{0, 16'h0000, 8'h00, 0, 0, 1, 0, 1,  1, 'hA, 0, 0, 'hEF};
        vecs[7]  = '{0, 16'h0000, 8'h00, 0, 0, 1, 0, 0,  1, 'h5, 1, 0, 'hEF};
        vecs[8]  = '{0, 16'h0000, 8'h00, 0, 0, 0, 0, 1,  1, 'h5, 0, 0, 'hEF};
        vecs[9]  = '{0, 16'h0000, 8'h00, 0, 0, 0, 0, 0,  1, 'h5, 0, 0, 'hEF};
        vecs[10] = '{0, 16'h0000, 8'h00, 0, 0, 1, 1, 1,  0, 'h5, 0, 0, 'hEF};
        vecs[11] = '{0, 16'hFF50, 8'h00, 0, 1, 0, 0, 0,  0, 'hA, 1, 0, 'hEF};
        vecs[12] = '{0, 16'hFF31, 8'h77, 1, 1, 0, 0, 0,  0, 'hA, 0, 1, 'h23};
        vecs[13] = '{0, 16'hFF31, 8'h00, 0, 1, 0, 0, 0,  0, 'hA, 0, 1, 'h77};
        vecs[14] = '{0, 16'hFF2F, 8'h00, 0, 1, 0, 0, 0,  0, 'hA, 0, 0, 'h77};

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].rst, vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].re,
                  vecs[i].play, vecs[i].trig, vecs[i].step);
            check($sformatf("vec%0d pos", i), int'(oPosition), vecs[i].ePos);
            check($sformatf("vec%0d sample", i), int'(oSample), vecs[i].eSample);
            check($sformatf("vec%0d sampleValid", i), int'(oSampleValid), vecs[i].eSv);
            check($sformatf("vec%0d dataValid", i), int'(oDataValid), vecs[i].eDv);
            check($sformatf("vec%0d data", i), int'(oData), vecs[i].eData);
        end

        // 32 back-to-back steps wrap the pointer and give one pulse per step
        cycle(1, 16'h0000, 8'h00, 0, 0, 0, 0, 0);
        cycle(0, 16'hFF30, 8'hA5, 1, 0, 0, 0, 0);
        cycle(0, 16'h0000, 8'h00, 0, 0, 1, 1, 0);
        svCount = 0;
        for (int i = 0; i < 32; i++) begin
            cycle(0, 16'h0000, 8'h00, 0, 0, 1, 0, 1);
            if (i > 0 && oSampleValid) svCount++;
            if (i == 30) check("wrap pos31", int'(oPosition), 31);
        end
        check("wrap pos0", int'(oPosition), 0);
        idle(1);
        if (oSampleValid) svCount++;
        check("wrap sample byte0 hi", int'(oSample), 'hA);
        check("wrap pulse count", svCount, 32);

        // Fetch and write to the same byte on one edge: fetch sees the old byte
        cycle(1, 16'h0000, 8'h00, 0, 0, 0, 0, 0);
        cycle(0, 16'h0000, 8'h00, 0, 0, 0, 1, 0);
        cycle(0, 16'hFF30, 8'h99, 1, 0, 0, 0, 0);
        check("rbw old sample", int'(oSample), 'h0);
        check("rbw old valid", int'(oSampleValid), 1);
        cycle(0, 16'h0000, 8'h00, 0, 0, 0, 1, 0);
        idle(0);
        check("rbw new sample", int'(oSample), 'h9);

        // Reset during a read aborts the pulse
        cycle(1, 16'hFF35, 8'h00, 0, 1, 0, 0, 0);
        check("reset read dv", int'(oDataValid), 0);
        check("reset read data", int'(oData), 0);

        // Access redirection while playing (lock build only)
        cycle(1, 16'h0000, 8'h00, 0, 0, 0, 0, 0);
        cycle(0, 16'h0000, 8'h00, 0, 0, 1, 1, 0);
        for (int i = 0; i < 6; i++) cycle(0, 16'h0000, 8'h00, 0, 0, 1, 0, 1);
        check("lock pos6", int'(oPosition), 6);
        cycle(0, 16'hFF3F, 8'h3C, 1, 0, 1, 0, 0);
`ifdef WAVE_RAM_LOCK_EN
        expB3 = 'h3C; expB15 = 'h10;
`else
        expB3 = 'h67; expB15 = 'h3C;
`endif
        cycle(0, 16'hFF33, 8'h00, 0, 1, 0, 0, 0);
        check("lock byte3", int'(oData), expB3);
        cycle(0, 16'hFF3F, 8'h00, 0, 1, 0, 0, 0);
        check("lock byte15", int'(oData), expB15);

        // Randomized run against the model
        cycle(1, 16'h0000, 8'h00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            a = ($urandom % 4 == 0) ? 16'($urandom) : (16'hFF30 | 16'($urandom % 16));
            cycle(($urandom % 150) == 0, a, 8'($urandom), ($urandom % 4) == 0,
                  ($urandom % 3) == 0, ($urandom % 4) != 0, ($urandom % 20) == 0,
                  ($urandom % 2) == 0);
            check("rand pos", int'(oPosition), mPos);
            check("rand sample", int'(oSample), mSample);
            check("rand sampleValid", int'(oSampleValid), mSv);
            check("rand dataValid", int'(oDataValid), mDv);
            check("rand data", int'(oData), mData);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
